regvec_streamer: RTL
====================

// Module: regvec_streamer
// PURPOSE
//  Read-side counterpart of the parallel register-file port: snapshots a flat NUM_ELEM x DATA_W vector on start,
//  then streams it out one element per accepted beat (index 0 first) over valid/ready. Feeds element-serial
//  datapaths (inner-product / residual update) in the OMP core from a parallel register image.
// PARAMETERS
//  DATA_W    16  width of one element, two's complement
//  NUM_ELEM  64  elements per vector (>=2)
//  IDX_W     $clog2(NUM_ELEM)  index width
// PORTS
//  clk        in   1                 clock
//  rst        in   1                 reset, asynchronous, active-high
//  start      in   1                 capture vec_in and begin streaming (accepted only in IDLE)
//  abort      in   1                 synchronous: drop the current stream and go to IDLE
//  vec_in     in   DATA_W*NUM_ELEM   parallel vector; element i = vec_in[DATA_W*(i+1)-1 -: DATA_W]
//  out_valid  out  1                 out_data/out_idx/out_last valid
//  out_ready  in   1                 consumer accepts the beat when out_valid&&out_ready
//  out_data   out  DATA_W            current element
//  out_idx    out  IDX_W             current element index
//  out_last   out  1                 high with index NUM_ELEM-1
//  busy       out  1                 high in STREAM and DONE
//  done       out  1                 one-cycle pulse after the last beat is accepted
// BEHAVIOUR
//  - Reset: state=IDLE; snapshot, out_data, out_idx, counters = 0; out_valid, out_last, busy, done = 0.
//  - FSM IDLE -> STREAM on start (cycle N): vec_in latched at edge N; out_valid=1 with idx 0 from cycle N+1.
//  - STREAM: beat accepted when out_valid&&out_ready -> idx++ next cycle. out_valid stays 1 until the last beat is accepted.
//    out_data/out_idx/out_last hold stable while out_valid&&!out_ready.
//  - Last beat (idx NUM_ELEM-1) accepted -> DONE for one cycle (done=1, out_valid=0) -> IDLE.
//  - Throughput: 1 element/cycle with out_ready held high; NUM_ELEM+1 cycles from start to done.
//  - start outside IDLE: ignored; the snapshot does not change. vec_in changes after capture: no effect.
//  - abort: highest priority after rst. Next cycle: IDLE, out_valid=0, idx=0, no done pulse.
//    abort and start in the same IDLE cycle: abort wins and the stream does not start.
//  - start in the DONE cycle: ignored. A new start is accepted from the following IDLE cycle.
//  - rst mid-stream: immediate return to reset values; no partial done.
//  - out_data is the raw element; no arithmetic applied to the stream.
// CONFIGURATION
//  Macro REGVEC_STREAMER_ARGMAX_EN. When defined, the block adds these outputs:
//   max_mag  out  DATA_W  unsigned max |element| over the accepted beats
//   max_idx  out  IDX_W   index of that element
//   - |x| is computed in DATA_W bits unsigned; -2^(DATA_W-1) maps to 2^(DATA_W-1), with no overflow.
//   - The outputs are cleared to 0 at start. They update on each accepted beat when |x| > max_mag (strict).
//     On ties the lowest index is kept.
//   - Final values are valid from the done cycle and held until the next start, rst or abort (abort clears them to 0).
//  When the macro is not defined, these ports and their logic do not exist; the rest of the behaviour is identical.
// STRUCTURE
//  - Shared defines header: DATA_W/NUM_ELEM defaults and the state encodings IDLE=2'd0, STREAM=2'd1, DONE=2'd2.
//  - Sub-module regvec_abs_cmp (combinational |x| and strict compare against the running max),
//    instantiated only under REGVEC_STREAMER_ARGMAX_EN.
//  - Element mux: indexed part-select on the snapshot with out_idx.
// TESTING
//  1. vec_in[i]=i+1, start pulse, out_ready=1 -> out_data 1..64 on consecutive cycles, out_last at idx 63,
//     done exactly 65 cycles after start.
//  2. out_ready toggles 1,0,0,1,... -> no beat lost or duplicated; data stable on every stalled cycle; done after the 64th accept.
//  3. start re-pulsed mid-stream with a different vec_in -> stream continues the original snapshot unchanged.
//  4. abort at idx 10 -> out_valid=0 next cycle, no done; new start -> stream restarts at idx 0 with the new vector.
//  5. rst asserted asynchronously at idx 5 -> all outputs 0 immediately; after rst drops, start streams normally.
//  6. ARGMAX_EN: elements {3,-7,7,-32768,...rest 0} -> max_mag=32768, max_idx=3;
//     with -32768 replaced by 0 -> max_mag=7, max_idx=1 (tie keeps the lower index).

Source files
------------

// File: rtl/regvec_streamer_pkg.sv
// ============================================================================
//  Module  : regvec_streamer_pkg
//  Brief   : Shared defaults and FSM state encoding for regvec_streamer.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package regvec_streamer_pkg;

   localparam int c_def_data_w   = 16;
   localparam int c_def_num_elem = 64;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/regvec_abs_cmp.sv
// ============================================================================
//  Module  : regvec_abs_cmp
//  Brief   : Combinational |x| (unsigned, DATA_W bits) and strict compare
//            against the running maximum.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module regvec_abs_cmp #(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] i_x,
   input  logic [DATA_W-1:0] i_cur_max,
   output logic [DATA_W-1:0] o_abs,
   output logic              o_gt
);

   // Two's-complement negate in DATA_W bits: the most negative value lands on
   // 2^(DATA_W-1), which is representable as unsigned.
   assign o_abs = i_x[DATA_W-1] ? (~i_x + 1'b1) : i_x;
   assign o_gt  = (o_abs > i_cur_max);

endmodule

`default_nettype wire

// File: rtl/regvec_streamer.sv
// ============================================================================
//  Module  : regvec_streamer
//  Brief   : Snapshots a NUM_ELEM x DATA_W vector on start and streams it out
//            one element per accepted valid/ready beat. Optional running
//            argmax of |element| under REGVEC_STREAMER_ARGMAX_EN.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module regvec_streamer
   import regvec_streamer_pkg::*;
#(
   parameter int DATA_W   = c_def_data_w,
   parameter int NUM_ELEM = c_def_num_elem,
   parameter int IDX_W    = $clog2(NUM_ELEM)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       abort,
   input  logic [DATA_W*NUM_ELEM-1:0] vec_in,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_W-1:0]          out_data,
   output logic [IDX_W-1:0]           out_idx,
   output logic                       out_last,
`ifdef REGVEC_STREAMER_ARGMAX_EN
   output logic [DATA_W-1:0]          max_mag,
   output logic [IDX_W-1:0]           max_idx,
`endif
   output logic                       busy,
   output logic                       done
);

   localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_ELEM - 1);

   state_t                       r_state;
   state_t                       w_state_next;
   logic [DATA_W*NUM_ELEM-1:0]   r_snap;
   logic [IDX_W-1:0]             r_idx;
   logic                         w_accept;
   logic                         w_last_accept;
   logic                         w_capture;

   assign out_valid     = (r_state == ST_STREAM);
   assign out_idx       = r_idx;
   assign out_data      = r_snap[r_idx*DATA_W +: DATA_W];
   assign out_last      = out_valid && (r_idx == c_last_idx);
   assign busy          = (r_state == ST_STREAM) || (r_state == ST_DONE);
   assign done          = (r_state == ST_DONE);

   assign w_accept      = out_valid && out_ready;
   assign w_last_accept = w_accept && (r_idx == c_last_idx);
   assign w_capture     = (r_state == ST_IDLE) && start && !abort;

   always_comb begin
      w_state_next = r_state;
      if (abort) begin
         w_state_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:   if (start) w_state_next = ST_STREAM;
            ST_STREAM: if (w_last_accept) w_state_next = ST_DONE;
            ST_DONE:   w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_snap  <= '0;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_capture) begin
            r_snap <= vec_in;
         end
         // Index returns to 0 after the last beat so non-power-of-two sizes work.
         if (abort || w_last_accept) begin
            r_idx <= '0;
         end else if (w_accept) begin
            r_idx <= r_idx + 1'b1;
         end
      end
   end

`ifdef REGVEC_STREAMER_ARGMAX_EN
   logic [DATA_W-1:0] r_max_mag;
   logic [IDX_W-1:0]  r_max_idx;
   logic [DATA_W-1:0] w_abs;
   logic              w_gt;

   regvec_abs_cmp #(
      .DATA_W    (DATA_W)
   ) u_abs_cmp (
      .i_x       (out_data),
      .i_cur_max (r_max_mag),
      .o_abs     (w_abs),
      .o_gt      (w_gt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_max_mag <= '0;
         r_max_idx <= '0;
      end else if (abort || w_capture) begin
         r_max_mag <= '0;
         r_max_idx <= '0;
      end else if (w_accept && w_gt) begin
         r_max_mag <= w_abs;
         r_max_idx <= r_idx;
      end
   end

   assign max_mag = r_max_mag;
   assign max_idx = r_max_idx;
`endif

endmodule

`default_nettype wire
